dc_motor_euler_fp: RTL and testbench
====================================

DC_MOTOR_EULER_FP -- requirements
Module: dc_motor_euler_fp

Interface
REQ-001 Parameter NUM_CH, default 1, number of independent motor channels (legal 1..16).
REQ-002 Parameter CH_W, default $clog2(NUM_CH) or 1 if NUM_CH=1, channel-index width.
REQ-003 clk  in  1  single clock; all logic synchronous to its rising edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 start  in  1  request one Euler step over all channels; honoured only in IDLE.
REQ-006 init  in  1  zero all channel states; honoured only in IDLE; start has priority if both are high.
REQ-007 coef  in  7x32  IEEE-754 single-precision {dt, inv_J, b_div_J, kt_div_J, k_e_div_L, R_div_L, inv_L}.
REQ-008 v  in  NUM_CHx32  per-channel applied voltage, IEEE single.
REQ-009 load  in  NUM_CHx32  per-channel load torque, IEEE single.
REQ-010 i_max  in  32  current magnitude limit, IEEE single; used only with the clamp feature.
REQ-011 busy  out  1  high from the cycle after an accepted start until done.
REQ-012 done  out  1  one-cycle pulse when every channel has been updated.
REQ-013 i_est  out  NUM_CHx32  per-channel current state.
REQ-014 w_est  out  NUM_CHx32  per-channel speed state.
REQ-015 clamp_flag  out  NUM_CH  sticky per-channel current-clamp indicator.

Function
REQ-016 On an accepted start, coef, v and load are captured; later input changes do not affect the step in progress.
REQ-017 FSM states are IDLE, CALC and DONE: IDLE->CALC on start; CALC->DONE after the last op of channel NUM_CH-1; DONE->IDLE unconditionally.
REQ-018 One FP multiplier and one FP adder are time-shared, chained combinationally, one op per cycle, with a 3-bit op counter and a channel counter.
REQ-019 Ops 0-2 produce acc_i = inv_L*v - R_div_L*i - k_e_div_L*w, starting from +0.0.
REQ-020 Ops 3-5 produce acc_w = kt_div_J*i - b_div_J*w - inv_J*load, starting from +0.0.
REQ-021 Subtraction is performed by inverting bit 31 of the product.
REQ-022 Op 6 computes i_next = i + dt*acc_i; op 7 computes w_next = w + dt*acc_w.
REQ-023 Ops 0-5 use the pre-step i and w; i_est[ch] and w_est[ch] are written together at the end of op 7.
REQ-024 Latency from the start edge to the done pulse is 8*NUM_CH+1 cycles; busy is high for 8*NUM_CH+1 cycles.
REQ-025 start or init asserted while busy is ignored and is not queued.
REQ-026 After the op-7 write the channel counter advances; after channel NUM_CH-1 it wraps to 0.
REQ-027 init in IDLE sets every i_est and w_est to +0.0 (32'h00000000) and clears clamp_flag on the next edge.
REQ-028 FP rounding, NaN and Inf behaviour is whatever the shared FP_mul/FP_adder primitives produce; the block adds no extra handling.

Reset
REQ-029 While rst_n is low: FSM is IDLE, counters are 0, busy=0, done=0, all i_est/w_est are 32'h00000000, clamp_flag is all-zero.
REQ-030 Reset asserted mid-step aborts the step, discards partial results and produces no done pulse.

Configuration
REQ-031 Macro DC_MOTOR_STATE_CLAMP_EN, when defined: if i_next[30:0] > i_max[30:0], the magnitude is replaced by i_max[30:0] with the sign kept, and clamp_flag[ch] is set.
REQ-032 When DC_MOTOR_STATE_CLAMP_EN is undefined: no clamp, i_max is unused, and clamp_flag is tied to 0.

Structure
REQ-033 A shared package dc_motor_pkg holds the FSM state enum, op-index constants, FP_ZERO, and the coef index localparams.
REQ-034 Per-channel i/w/clamp registers, with write port and init clear, live in one sub-module dc_motor_state_bank; the existing FP_mul and FP_adder primitives are instantiated once each.

Verification
REQ-035 NUM_CH=1, all coef 0 except inv_L=dt=1.0 (3F800000), v=2.0 -> after one step i_est=40000000, w_est=0, done at cycle 9.
REQ-036 Same setup, three back-to-back starts -> i_est=40C00000 (6.0) and exactly three done pulses.
REQ-037 NUM_CH=4, per-channel v = 1.0, 2.0, 3.0, 4.0, inv_L=dt=1.0 -> channels differ correctly; done at cycle 33; start pulsed mid-step is ignored.
REQ-038 kt_div_J=1.0, dt=0.5, i preset 2.0 via prior step, load=0 -> w_est=3F800000.
REQ-039 Clamp build, i_max=1.0, inv_L=dt=1.0, v=-5.0 -> i_est=BF800000, clamp_flag=1; init clears both.
REQ-040 rst_n dropped at cycle 4 of a step -> outputs all zero, no done pulse; a fresh start completes normally.

Source files
------------

// File: rtl/dc_motor_pkg.sv
// Shared types and constants for the DC motor Euler integrator.
// Coefficient slots follow the packed order {dt, ..., inv_L} (inv_L in slot 0).
package dc_motor_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_DONE
  } state_e;

  localparam logic [2:0] OP_I_V  = 3'd0;
  localparam logic [2:0] OP_I_R  = 3'd1;
  localparam logic [2:0] OP_I_KE = 3'd2;
  localparam logic [2:0] OP_W_KT = 3'd3;
  localparam logic [2:0] OP_W_B  = 3'd4;
  localparam logic [2:0] OP_W_LD = 3'd5;
  localparam logic [2:0] OP_I_NX = 3'd6;
  localparam logic [2:0] OP_W_NX = 3'd7;

  localparam logic [31:0] FP_ZERO = 32'h0000_0000;

  localparam int NUM_COEF   = 7;
  localparam int C_INV_L    = 0;
  localparam int C_R_DIV_L  = 1;
  localparam int C_KE_DIV_L = 2;
  localparam int C_KT_DIV_J = 3;
  localparam int C_B_DIV_J  = 4;
  localparam int C_INV_J    = 5;
  localparam int C_DT       = 6;

endpackage

// File: rtl/dc_motor_euler_fp_if.sv
// Control/data bundle between a motor-step requester and dc_motor_euler_fp.
// Slots of coef, from bit 0 up: inv_L, R_div_L, k_e_div_L, kt_div_J, b_div_J, inv_J, dt.
interface dc_motor_euler_fp_if #(
  parameter int NUM_CH = 1
);
  logic                     start;
  logic                     init;
  logic [6:0][31:0]         coef;
  logic [NUM_CH-1:0][31:0]  v;
  logic [NUM_CH-1:0][31:0]  load;
  logic [31:0]              i_max;
  logic                     busy;
  logic                     done;
  logic [NUM_CH-1:0][31:0]  i_est;
  logic [NUM_CH-1:0][31:0]  w_est;
  logic [NUM_CH-1:0]        clamp_flag;

  modport master (
    output start, init, coef, v, load, i_max,
    input  busy, done, i_est, w_est, clamp_flag
  );

  modport slave (
    input  start, init, coef, v, load, i_max,
    output busy, done, i_est, w_est, clamp_flag
  );
endinterface

// File: rtl/FP_adder.sv
// Combinational IEEE-754 single adder, round-to-nearest-even.
// Subnormals flush to zero; an exact cancellation gives +0.
module FP_adder (
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic [31:0] y_o
);
  logic [31:0]       x, z;
  logic [7:0]        d;
  logic [26:0]       mx, mz, mzs, lost;
  logic [27:0]       s;
  logic signed [9:0] e;
  logic [4:0]        lz;
  logic [24:0]       mr;
  logic              found;

  always_comb begin
    if (a_i[30:0] >= b_i[30:0]) begin
      x = a_i;
      z = b_i;
    end else begin
      x = b_i;
      z = a_i;
    end
    d    = x[30:23] - z[30:23];
    mx   = (x[30:23] != 8'd0) ? {1'b1, x[22:0], 3'b000} : 27'd0;
    mz   = (z[30:23] != 8'd0) ? {1'b1, z[22:0], 3'b000} : 27'd0;
    lost = 27'd0;
    if (d > 8'd26) begin
      mzs = {26'd0, |mz};
    end else begin
      lost = mz & ~({27{1'b1}} << d);
      mzs  = (mz >> d) | {26'd0, |lost};
    end
    if (x[31] == z[31]) s = {1'b0, mx} + {1'b0, mzs};
    else                s = {1'b0, mx} - {1'b0, mzs};
    e     = $signed({2'b00, x[30:23]});
    lz    = 5'd0;
    found = 1'b0;
    for (int k = 26; k >= 0; k--) begin
      if (!found && s[k]) begin
        lz    = 5'(26 - k);
        found = 1'b1;
      end
    end
    if (s[27]) begin
      s = {1'b0, s[27:2], s[1] | s[0]};
      e = e + 10'sd1;
    end else begin
      s = s << lz;
      e = e - $signed({5'd0, lz});
    end
    mr = {1'b0, s[26:3]} + {24'd0, s[2] & (s[1] | s[0] | s[3])};
    if (mr[24]) begin
      mr = 25'd0;
      e  = e + 10'sd1;
    end
    if (x[30:23] == 8'hff)   y_o = x;
    else if (s == 28'd0)     y_o = 32'd0;
    else if (e >= 10'sd255)  y_o = {x[31], 8'hff, 23'd0};
    else if (e <= 10'sd0)    y_o = {x[31], 31'd0};
    else                     y_o = {x[31], e[7:0], mr[22:0]};
  end
endmodule

// File: rtl/FP_mul.sv
// Combinational IEEE-754 single multiplier, round-to-nearest-even.
// Subnormals flush to zero; any NaN input yields a quiet NaN.
module FP_mul (
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic [31:0] y_o
);
  logic [47:0]       p;
  logic signed [9:0] e;
  logic [23:0]       m;
  logic              sg, g, st, co;

  always_comb begin
    sg = a_i[31] ^ b_i[31];
    p  = 48'({1'b1, a_i[22:0]}) * 48'({1'b1, b_i[22:0]});
    e  = $signed({2'b00, a_i[30:23]}) + $signed({2'b00, b_i[30:23]})
         - 10'sd127;
    if (p[47]) begin
      m  = p[47:24];
      g  = p[23];
      st = |p[22:0];
      e  = e + 10'sd1;
    end else begin
      m  = p[46:23];
      g  = p[22];
      st = |p[21:0];
    end
    {co, m} = {1'b0, m} + 25'(g & (st | m[0]));
    if (co) begin
      m = 24'h80_0000;
      e = e + 10'sd1;
    end
    y_o = {sg, e[7:0], m[22:0]};
    if (a_i[30:23] == 8'hff || b_i[30:23] == 8'hff) begin
      if ((a_i[30:23] == 8'hff && a_i[22:0] != 23'd0) ||
          (b_i[30:23] == 8'hff && b_i[22:0] != 23'd0))
        y_o = 32'h7fc0_0000;
      else
        y_o = {sg, 8'hff, 23'd0};
    end else if (a_i[30:23] == 8'd0 || b_i[30:23] == 8'd0 || e <= 10'sd0) begin
      y_o = {sg, 31'd0};
    end else if (e >= 10'sd255) begin
      y_o = {sg, 8'hff, 23'd0};
    end
  end
endmodule

// File: rtl/dc_motor_state_bank.sv
// Per-channel current/speed state and sticky clamp flags.
// One write port (both states at once) plus a bulk clear.
module dc_motor_state_bank
  import dc_motor_pkg::*;
#(
  parameter int NUM_CH = 1,
  parameter int CH_W   = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clr_i,
  input  logic                    we_i,
  input  logic [CH_W-1:0]         ch_i,
  input  logic [31:0]             i_d_i,
  input  logic [31:0]             w_d_i,
  input  logic                    clamp_i,
  output logic [NUM_CH-1:0][31:0] i_o,
  output logic [NUM_CH-1:0][31:0] w_o,
  output logic [NUM_CH-1:0]       clamp_o
);
  logic [NUM_CH-1:0][31:0] i_q, w_q;
  logic [NUM_CH-1:0]       clamp_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      i_q     <= '0;
      w_q     <= '0;
      clamp_q <= '0;
    end else if (clr_i) begin
      i_q     <= {NUM_CH{FP_ZERO}};
      w_q     <= {NUM_CH{FP_ZERO}};
      clamp_q <= '0;
    end else if (we_i) begin
      i_q[ch_i]     <= i_d_i;
      w_q[ch_i]     <= w_d_i;
      clamp_q[ch_i] <= clamp_q[ch_i] | clamp_i;
    end
  end

  assign i_o     = i_q;
  assign w_o     = w_q;
  assign clamp_o = clamp_q;
endmodule

// File: rtl/dc_motor_euler_fp.sv
// Multi-channel DC motor forward-Euler step on one shared FP mul+add pair.
// Optional current clamp: define DC_MOTOR_STATE_CLAMP_EN.
module dc_motor_euler_fp
  import dc_motor_pkg::*;
#(
  parameter int NUM_CH = 1,
  parameter int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic            clk,
  input  logic            rst_n,
  dc_motor_euler_fp_if.slave bus
);
  state_e                    state_q, state_d;
  logic [2:0]                op_q, op_d;
  logic [CH_W-1:0]           ch_q, ch_d;
  logic [NUM_COEF-1:0][31:0] coef_q;
  logic [NUM_CH-1:0][31:0]   v_q, load_q;
  logic [31:0]               acc_q, acc_d, acc_i_q, acc_i_d;
  logic [31:0]               i_nx_q, i_nx_d;
  logic                      clamp_hit_q, clamp_hit_d;
  logic                      cap, clr, we, neg, clamp_now;
  logic [31:0]               mul_a, mul_b, prod, add_a, add_b, sum;
  logic [31:0]               i_lim, i_cur, w_cur;
  logic [NUM_CH-1:0][31:0]   i_all, w_all;
  logic [NUM_CH-1:0]         clamp_all;

  assign i_cur = i_all[ch_q];
  assign w_cur = w_all[ch_q];

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    ch_d    = ch_q;
    cap     = 1'b0;
    clr     = 1'b0;
    we      = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_CALC;
          cap     = 1'b1;
          op_d    = OP_I_V;
          ch_d    = '0;
        end else if (bus.init) begin
          clr = 1'b1;
        end
      end
      S_CALC: begin
        op_d = op_q + 3'd1;
        if (op_q == OP_W_NX) begin
          we = 1'b1;
          if (ch_q == CH_W'(NUM_CH - 1)) begin
            ch_d    = '0;
            state_d = S_DONE;
          end else begin
            ch_d = ch_q + 1'b1;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Each op is one multiply feeding one add; neg turns the add into a subtract.
  always_comb begin
    mul_a = FP_ZERO;
    mul_b = FP_ZERO;
    add_a = FP_ZERO;
    neg   = 1'b0;
    unique case (op_q)
      OP_I_V:  begin mul_a = coef_q[C_INV_L];    mul_b = v_q[ch_q];    end
      OP_I_R:  begin mul_a = coef_q[C_R_DIV_L];  mul_b = i_cur;
                     add_a = acc_q; neg = 1'b1; end
      OP_I_KE: begin mul_a = coef_q[C_KE_DIV_L]; mul_b = w_cur;
                     add_a = acc_q; neg = 1'b1; end
      OP_W_KT: begin mul_a = coef_q[C_KT_DIV_J]; mul_b = i_cur;        end
      OP_W_B:  begin mul_a = coef_q[C_B_DIV_J];  mul_b = w_cur;
                     add_a = acc_q; neg = 1'b1; end
      OP_W_LD: begin mul_a = coef_q[C_INV_J];    mul_b = load_q[ch_q];
                     add_a = acc_q; neg = 1'b1; end
      OP_I_NX: begin mul_a = coef_q[C_DT];       mul_b = acc_i_q;
                     add_a = i_cur; end
      OP_W_NX: begin mul_a = coef_q[C_DT];       mul_b = acc_q;
                     add_a = w_cur; end
      default: ;
    endcase
  end

  assign add_b = {prod[31] ^ neg, prod[30:0]};

  FP_mul u_mul (.a_i(mul_a), .b_i(mul_b), .y_o(prod));
  FP_adder u_add (.a_i(add_a), .b_i(add_b), .y_o(sum));

`ifdef DC_MOTOR_STATE_CLAMP_EN
  assign clamp_now = sum[30:0] > bus.i_max[30:0];
  assign i_lim     = clamp_now ? {sum[31], bus.i_max[30:0]} : sum;
`else
  assign clamp_now = 1'b0;
  assign i_lim     = sum;
`endif

  always_comb begin
    acc_d       = acc_q;
    acc_i_d     = acc_i_q;
    i_nx_d      = i_nx_q;
    clamp_hit_d = clamp_hit_q;
    if (state_q == S_CALC) begin
      unique case (op_q)
        OP_I_KE: acc_i_d = sum;
        OP_I_NX: begin
          i_nx_d      = i_lim;
          clamp_hit_d = clamp_now;
        end
        OP_W_NX: ;
        default: acc_d = sum;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      ch_q    <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      ch_q    <= ch_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      coef_q      <= '0;
      v_q         <= '0;
      load_q      <= '0;
      acc_q       <= FP_ZERO;
      acc_i_q     <= FP_ZERO;
      i_nx_q      <= FP_ZERO;
      clamp_hit_q <= 1'b0;
    end else begin
      if (cap) begin
        coef_q <= bus.coef;
        v_q    <= bus.v;
        load_q <= bus.load;
      end
      acc_q       <= acc_d;
      acc_i_q     <= acc_i_d;
      i_nx_q      <= i_nx_d;
      clamp_hit_q <= clamp_hit_d;
    end
  end

  dc_motor_state_bank #(
    .NUM_CH (NUM_CH),
    .CH_W   (CH_W)
  ) u_bank (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr_i   (clr),
    .we_i    (we),
    .ch_i    (ch_q),
    .i_d_i   (i_nx_q),
    .w_d_i   (sum),
    .clamp_i (clamp_hit_q),
    .i_o     (i_all),
    .w_o     (w_all),
    .clamp_o (clamp_all)
  );

  assign bus.busy       = (state_q != S_IDLE);
  assign bus.done       = (state_q == S_DONE);
  assign bus.i_est      = i_all;
  assign bus.w_est      = w_all;
  assign bus.clamp_flag = clamp_all;
endmodule

// File: tb/tb_dc_motor_euler_fp.sv
// Bench for dc_motor_euler_fp: 1- and 4-channel instances against a real-valued model.
// Stimulus uses dyadic values so every float result is exact.
module tb_dc_motor_euler_fp;
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dc_motor_euler_fp_if #(.NUM_CH(1)) b1 ();
  dc_motor_euler_fp_if #(.NUM_CH(4)) b4 ();

  dc_motor_euler_fp #(.NUM_CH(1)) u1 (.clk(clk), .rst_n(rst_n), .bus(b1));
  dc_motor_euler_fp #(.NUM_CH(4)) u4 (.clk(clk), .rst_n(rst_n), .bus(b4));

`ifdef DC_MOTOR_STATE_CLAMP_EN
  localparam bit CLAMP = 1'b1;
`else
  localparam bit CLAMP = 1'b0;
`endif

  int checks = 0;
  int errors = 0;
  int dn1 = 0;
  int dn4 = 0;

  real c1[7];
  real c4[7];
  real v1, l1, mx1, mx4;
  real v4[4];
  real l4[4];
  real mi1, mw1;
  bit  mf1;
  real mi4[4];
  real mw4[4];
  bit  mf4[4];

  always @(negedge clk) begin
    if (b1.done === 1'b1) dn1++;
    if (b4.done === 1'b1) dn4++;
  end

  function automatic logic [31:0] r2f(input real r);
    logic   s;
    int     e;
    real    a;
    longint f;
    if (r == 0.0) return 32'd0;
    s = (r < 0.0);
    a = s ? -r : r;
    e = 127;
    while (a >= 2.0) begin a = a / 2.0; e++; end
    while (a < 1.0)  begin a = a * 2.0; e--; end
    f = longint'((a - 1.0) * 8388608.0);
    return {s, 8'(e), f[22:0]};
  endfunction

  // Continuous-time motor equations discretised by forward Euler.
  task automatic mstep(input real c[7], input real vv, input real ll,
                       input real mx, inout real i, inout real w,
                       inout bit f);
    real ai, aw, ni, nw;
    ai = c[0] * vv - c[1] * i - c[2] * w;
    aw = c[3] * i - c[4] * w - c[5] * ll;
    ni = i + c[6] * ai;
    nw = w + c[6] * aw;
    if (CLAMP && (ni > mx || ni < -mx)) begin
      ni = (ni < 0.0) ? -mx : mx;
      f  = 1'b1;
    end
    i = ni;
    w = nw;
  endtask

  task automatic drive1();
    b1.coef = {r2f(c1[6]), r2f(c1[5]), r2f(c1[4]), r2f(c1[3]),
               r2f(c1[2]), r2f(c1[1]), r2f(c1[0])};
    b1.v[0]    = r2f(v1);
    b1.load[0] = r2f(l1);
    b1.i_max   = r2f(mx1);
  endtask

  task automatic drive4();
    b4.coef = {r2f(c4[6]), r2f(c4[5]), r2f(c4[4]), r2f(c4[3]),
               r2f(c4[2]), r2f(c4[1]), r2f(c4[0])};
    for (int k = 0; k < 4; k++) begin
      b4.v[k]    = r2f(v4[k]);
      b4.load[k] = r2f(l4[k]);
    end
    b4.i_max = r2f(mx4);
  endtask

  task automatic clear1();
    for (int k = 0; k < 7; k++) c1[k] = 0.0;
    v1 = 0.0; l1 = 0.0; mx1 = 1.0;
  endtask

  task automatic init_both();
    @(negedge clk);
    b1.init = 1'b1;
    b4.init = 1'b1;
    @(negedge clk);
    b1.init = 1'b0;
    b4.init = 1'b0;
    mi1 = 0.0; mw1 = 0.0; mf1 = 1'b0;
    for (int k = 0; k < 4; k++) begin
      mi4[k] = 0.0; mw4[k] = 0.0; mf4[k] = 1'b0;
    end
  endtask

  task automatic run1(output int lat);
    int n;
    @(negedge clk);
    b1.start = 1'b1;
    @(negedge clk);
    b1.start = 1'b0;
    n = 1;
    while (b1.done !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (b1.done !== 1'b1) begin
      errors++;
      $display("FAIL run1_timeout: done=%b after %0d cycles, required 1", b1.done, n);
    end
    lat = n;
  endtask

  task automatic run4(input bit poke, output int lat, output int bn);
    int n;
    @(negedge clk);
    b4.start = 1'b1;
    @(negedge clk);
    b4.start = 1'b0;
    n  = 1;
    bn = 0;
    while (n < 300) begin
      if (b4.busy === 1'b1) bn++;
      if (b4.done === 1'b1) break;
      if (poke && n == 10) begin
        b4.start   = 1'b1;
        b4.init    = 1'b1;
        b4.v[0]    = 32'h4120_0000;
        b4.load[1] = 32'hc0a0_0000;
        b4.coef[0] = 32'h4000_0000;
      end
      if (poke && n == 11) begin
        b4.start = 1'b0;
        b4.init  = 1'b0;
      end
      @(negedge clk);
      n++;
    end
    checks++;
    if (b4.done !== 1'b1) begin
      errors++;
      $display("FAIL run4_timeout: done=%b after %0d cycles, required 1", b4.done, n);
    end
    lat = n;
    drive4();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks += 6;
    if (b1.busy !== 1'b0 || b1.done !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctl1: busy=%b done=%b, required 0 0", b1.busy, b1.done);
    end
    if (b1.i_est !== 32'd0 || b1.w_est !== 32'd0) begin
      errors++;
      $display("FAIL reset_state1: i=%h w=%h, required 0", b1.i_est, b1.w_est);
    end
    if (b1.clamp_flag !== 1'b0) begin
      errors++;
      $display("FAIL reset_clamp1: got %b, required 0", b1.clamp_flag);
    end
    if (b4.busy !== 1'b0 || b4.done !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctl4: busy=%b done=%b, required 0 0", b4.busy, b4.done);
    end
    if (b4.i_est !== 128'd0 || b4.w_est !== 128'd0) begin
      errors++;
      $display("FAIL reset_state4: i=%h w=%h, required 0", b4.i_est, b4.w_est);
    end
    if (b4.clamp_flag !== 4'd0) begin
      errors++;
      $display("FAIL reset_clamp4: got %b, required 0", b4.clamp_flag);
    end
    rst_n = 1'b1;
    mi1 = 0.0; mw1 = 0.0; mf1 = 1'b0;
    for (int k = 0; k < 4; k++) begin
      mi4[k] = 0.0; mw4[k] = 0.0; mf4[k] = 1'b0;
    end
  endtask

  task automatic test_single();
    int lat;
    clear1();
    c1[0] = 1.0; c1[6] = 1.0; v1 = 2.0;
    drive1();
    mstep(c1, v1, l1, mx1, mi1, mw1, mf1);
    run1(lat);
    checks += 3;
    if (lat != 9) begin
      errors++;
      $display("FAIL single_latency: got %0d, required 9", lat);
    end
    if (b1.i_est !== 32'h4000_0000 || b1.i_est !== r2f(mi1)) begin
      errors++;
      $display("FAIL single_i: got %h, required 40000000", b1.i_est);
    end
    if (b1.w_est !== 32'h0) begin
      errors++;
      $display("FAIL single_w: got %h, required 00000000", b1.w_est);
    end
  endtask

  task automatic test_back_to_back();
    int lat, d0;
    init_both();
    @(negedge clk);
    checks++;
    if (b1.i_est !== 32'd0) begin
      errors++;
      $display("FAIL init_clear: got %h, required 00000000", b1.i_est);
    end
    d0 = dn1;
    for (int s = 0; s < 3; s++) begin
      mstep(c1, v1, l1, mx1, mi1, mw1, mf1);
      run1(lat);
    end
    repeat (5) @(negedge clk);
    checks += 3;
    if (b1.i_est !== 32'h40c0_0000 || b1.i_est !== r2f(mi1)) begin
      errors++;
      $display("FAIL b2b_i: got %h, required 40c00000", b1.i_est);
    end
    if (dn1 - d0 != 3) begin
      errors++;
      $display("FAIL b2b_done_count: got %0d, required 3", dn1 - d0);
    end
    if (b1.busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b_idle: busy=%b, required 0", b1.busy);
    end
  endtask

  task automatic test_torque();
    int lat;
    init_both();
    clear1();
    c1[0] = 1.0; c1[6] = 1.0; v1 = 2.0;
    drive1();
    mstep(c1, v1, l1, mx1, mi1, mw1, mf1);
    run1(lat);
    clear1();
    c1[3] = 1.0; c1[6] = 0.5; v1 = 2.0; l1 = 0.0;
    drive1();
    mstep(c1, v1, l1, mx1, mi1, mw1, mf1);
    run1(lat);
    checks += 2;
    if (b1.w_est !== 32'h3f80_0000 || b1.w_est !== r2f(mw1)) begin
      errors++;
      $display("FAIL torque_w: got %h, required 3f800000", b1.w_est);
    end
    if (b1.i_est !== 32'h4000_0000) begin
      errors++;
      $display("FAIL torque_i: got %h, required 40000000", b1.i_est);
    end
  endtask

  task automatic test_clamp();
    int lat;
    logic [31:0] exp_i;
    init_both();
    clear1();
    c1[0] = 1.0; c1[6] = 1.0; v1 = -5.0; mx1 = 1.0;
    drive1();
    mstep(c1, v1, l1, mx1, mi1, mw1, mf1);
    run1(lat);
    exp_i = CLAMP ? 32'hbf80_0000 : 32'hc0a0_0000;
    checks += 2;
    if (b1.i_est !== exp_i || b1.i_est !== r2f(mi1)) begin
      errors++;
      $display("FAIL clamp_i: got %h, required %h", b1.i_est, exp_i);
    end
    if (b1.clamp_flag !== mf1) begin
      errors++;
      $display("FAIL clamp_flag: got %b, required %b", b1.clamp_flag, mf1);
    end
    init_both();
    @(negedge clk);
    checks++;
    if (b1.i_est !== 32'd0 || b1.clamp_flag !== 1'b0) begin
      errors++;
      $display("FAIL clamp_init: i=%h flag=%b, required 0 0", b1.i_est, b1.clamp_flag);
    end
  endtask

  task automatic test_channels();
    int lat, bn, d0;
    logic [31:0] exp_i;
    for (int k = 0; k < 7; k++) c4[k] = 0.0;
    c4[0] = 1.0; c4[6] = 1.0; mx4 = 8.0;
    for (int k = 0; k < 4; k++) begin
      v4[k] = real'(k + 1);
      l4[k] = 0.0;
    end
    drive4();
    for (int k = 0; k < 4; k++)
      mstep(c4, v4[k], l4[k], mx4, mi4[k], mw4[k], mf4[k]);
    d0 = dn4;
    run4(1'b1, lat, bn);
    checks += 2;
    if (lat != 33) begin
      errors++;
      $display("FAIL ch_latency: got %0d, required 33", lat);
    end
    if (bn != 33) begin
      errors++;
      $display("FAIL ch_busy_len: got %0d, required 33", bn);
    end
    for (int k = 0; k < 4; k++) begin
      exp_i = r2f(real'(k + 1));
      checks++;
      if (b4.i_est[k] !== exp_i || b4.i_est[k] !== r2f(mi4[k])) begin
        errors++;
        $display("FAIL ch_i[%0d]: got %h, required %h", k, b4.i_est[k], exp_i);
      end
    end
    repeat (4) @(negedge clk);
    checks += 2;
    if (b4.busy !== 1'b0) begin
      errors++;
      $display("FAIL ch_ignored_start: busy=%b, required 0", b4.busy);
    end
    if (dn4 - d0 != 1) begin
      errors++;
      $display("FAIL ch_done_count: got %0d, required 1", dn4 - d0);
    end
  endtask

  task automatic test_reset_mid();
    int n, d0, lat, bn;
    for (int k = 0; k < 7; k++) c4[k] = 0.0;
    c4[0] = 1.0; c4[3] = 0.5; c4[6] = 0.5;
    for (int k = 0; k < 4; k++) begin
      v4[k] = real'(2 * k) - 3.0;
      l4[k] = real'(k);
    end
    drive4();
    d0 = dn4;
    @(negedge clk);
    b4.start = 1'b1;
    @(negedge clk);
    b4.start = 1'b0;
    n = 1;
    while (n < 4) begin
      @(negedge clk);
      n++;
    end
    rst_n = 1'b0;
    #1;
    checks += 2;
    if (b4.busy !== 1'b0 || b4.done !== 1'b0) begin
      errors++;
      $display("FAIL midrst_ctl: busy=%b done=%b, required 0 0", b4.busy, b4.done);
    end
    if (b4.i_est !== 128'd0 || b4.w_est !== 128'd0 || b4.clamp_flag !== 4'd0) begin
      errors++;
      $display("FAIL midrst_state: i=%h w=%h, required 0", b4.i_est, b4.w_est);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    checks++;
    if (dn4 != d0) begin
      errors++;
      $display("FAIL midrst_no_done: got %0d pulses, required 0", dn4 - d0);
    end
    mi1 = 0.0; mw1 = 0.0; mf1 = 1'b0;
    for (int k = 0; k < 4; k++) begin
      mi4[k] = 0.0; mw4[k] = 0.0; mf4[k] = 1'b0;
      mstep(c4, v4[k], l4[k], mx4, mi4[k], mw4[k], mf4[k]);
    end
    run4(1'b0, lat, bn);
    checks++;
    if (lat != 33) begin
      errors++;
      $display("FAIL midrst_fresh_latency: got %0d, required 33", lat);
    end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (b4.i_est[k] !== r2f(mi4[k]) || b4.w_est[k] !== r2f(mw4[k])) begin
        errors++;
        $display("FAIL midrst_fresh[%0d]: i=%h w=%h, required %h %h",
                 k, b4.i_est[k], b4.w_est[k], r2f(mi4[k]), r2f(mw4[k]));
      end
    end
  endtask

  task automatic test_random();
    int  lat, bn;
    real tab[3];
    real dtt[3];
    tab[0] = 0.0;  tab[1] = 0.5; tab[2] = 1.0;
    dtt[0] = 0.25; dtt[1] = 0.5; dtt[2] = 1.0;
    for (int it = 0; it < 4; it++) begin
      init_both();
      for (int s = 0; s < 3; s++) begin
        for (int k = 0; k < 6; k++) c4[k] = tab[$urandom_range(0, 2)];
        c4[6] = dtt[$urandom_range(0, 2)];
        for (int k = 0; k < 4; k++) begin
          v4[k] = real'($urandom_range(0, 16)) - 8.0;
          l4[k] = real'($urandom_range(0, 16)) - 8.0;
        end
        mx4 = real'($urandom_range(1, 8));
        drive4();
        for (int k = 0; k < 4; k++)
          mstep(c4, v4[k], l4[k], mx4, mi4[k], mw4[k], mf4[k]);
        run4(s == 1, lat, bn);
        checks++;
        if (lat != 33) begin
          errors++;
          $display("FAIL rnd_latency it%0d s%0d: got %0d, required 33", it, s, lat);
        end
        for (int k = 0; k < 4; k++) begin
          checks++;
          if (b4.i_est[k] !== r2f(mi4[k]) || b4.w_est[k] !== r2f(mw4[k]) ||
              b4.clamp_flag[k] !== mf4[k]) begin
            errors++;
            $display("FAIL rnd it%0d s%0d ch%0d: i=%h w=%h f=%b, required %h %h %b",
                     it, s, k, b4.i_est[k], b4.w_est[k], b4.clamp_flag[k],
                     r2f(mi4[k]), r2f(mw4[k]), mf4[k]);
          end
        end
      end
    end
  endtask

  initial begin
    b1.start = 1'b0; b1.init = 1'b0; b1.coef = '0;
    b1.v = '0; b1.load = '0; b1.i_max = '0;
    b4.start = 1'b0; b4.init = 1'b0; b4.coef = '0;
    b4.v = '0; b4.load = '0; b4.i_max = '0;
    for (int k = 0; k < 7; k++) c4[k] = 0.0;
    mx4 = 8.0;
    test_reset();
    test_single();
    test_back_to_back();
    test_torque();
    test_clamp();
    test_channels();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
